mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: N, 32, operand and HI/LO register width; only 32 is supported.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: Start  input  1  request to begin an operation; sampled on a rising edge.
REQ-005 Port: Op  input  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 Port: OperandA  input  32  rs value from register file ReadData1; multiplicand or dividend.
REQ-007 Port: OperandB  input  32  rt value from register file ReadData2; multiplier or divisor.
REQ-008 Port: WriteHi  input  1  MTHI; load HI from WriteData.
REQ-009 Port: WriteLo  input  1  MTLO; load LO from WriteData.
REQ-010 Port: WriteData  input  32  data for MTHI/MTLO.
REQ-011 Port: ReadSel  input  1  0 selects LO, 1 selects HI, for MFLO/MFHI.
REQ-012 Port: Busy  output  1  high while an operation is in progress.
REQ-013 Port: Done  output  1  one-cycle pulse when an operation completes.
REQ-014 Port: DivByZero  output  1  qualifies Done; high when a DIV/DIVU had OperandB==0.
REQ-015 Port: ResultData  output  32  the value of HI or LO selected by ReadSel, sent to write-back.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and FINISH.
REQ-017 The FSM SHALL move IDLE->RUN on Start=1.
  - On that edge it latches Op.
  - It loads the operand magnitudes; for MULT/DIV, negative operands are two's-complement negated.
  - It records the sign flags and clears a 6-bit iteration counter.
REQ-018 Start SHALL be ignored in RUN and FINISH, with no effect on the operation in progress.
REQ-019 RUN SHALL perform exactly 32 iterations, one per edge.
  - Multiply: shift-add, one multiplier bit per iteration.
  - Divide: restoring division, one quotient bit per iteration.
REQ-020 After the 32nd iteration the FSM SHALL enter FINISH.
REQ-021 The FSM SHALL move FINISH->IDLE unconditionally on the next edge.
  - On that edge it writes HI/LO with sign correction applied.
  - Done=1 for exactly the following cycle.
REQ-022 Latency SHALL be fixed: if Start is sampled at edge k, HI/LO update at edge k+33 and Done is high between edges k+33 and k+34.
REQ-023 Busy SHALL be high whenever the state is not IDLE, i.e. from edge k to edge k+33.
REQ-024 Multiply results SHALL be {HI,LO} = the 64-bit product.
  - MULT: the product is negated if exactly one operand is negative.
  - Example: MULT 0x80000000*0x80000000 = 0x40000000_00000000.
REQ-025 Divide results SHALL be LO = quotient and HI = remainder.
  - DIV: the quotient is negated if the operand signs differ.
  - DIV: the remainder takes the sign of the dividend.
REQ-026 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 (wrap) and HI=0x00000000.
REQ-027 For DIV/DIVU with OperandB==0:
  - the full 33-cycle sequence still runs;
  - HI and LO are left unmodified;
  - DivByZero=1 during the Done cycle.
REQ-028 DivByZero SHALL be 0 at all times outside a divide-by-zero Done cycle.
REQ-029 WriteHi/WriteLo SHALL be honoured only in IDLE; they are ignored in RUN and FINISH.
REQ-030 If Start and WriteHi/WriteLo occur on the same IDLE edge, both SHALL take effect; the operation result later overwrites HI/LO.
REQ-031 WriteHi and WriteLo together SHALL load both registers with WriteData.
REQ-032 ResultData SHALL be combinational: ReadSel ? HI : LO.
  - It reflects any HI/LO update in the cycle after the updating edge.
  - During RUN it shows the previous HI/LO, not partial results.
REQ-033 Operand inputs SHALL be sampled only on the Start edge; changes during RUN have no effect.

Reset
REQ-034 rst=1 SHALL asynchronously force:
  - state IDLE, iteration counter 0;
  - HI=0, LO=0, all internal datapath registers 0;
  - Busy=0, Done=0, DivByZero=0, hence ResultData=0.
REQ-035 rst asserted mid-operation SHALL abort the operation with no HI/LO write and no Done pulse.
REQ-036 A Start on the first edge after rst deasserts SHALL be accepted normally.

Verification
REQ-037 MULTU: Start with A=0xFFFFFFFF, B=0xFFFFFFFF -> Done at cycle 33, HI=0xFFFFFFFE, LO=0x00000001, Busy high for 33 cycles.
REQ-038 MULT: A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
REQ-039 DIV: A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - DIVU: A=100, B=7 -> LO=14, HI=2.
REQ-040 DIVU with B=0 after MTHI 0x1234 / MTLO 0x5678:
  - DivByZero=1 with Done;
  - HI=0x1234 and LO=0x5678 are retained.
REQ-041 Start plus WriteLo=0xAAAA mid-RUN -> both ignored; the original result is written at cycle 33 and Done pulses once.
REQ-042 rst pulse at cycle 10 of a MULTU -> Busy=0 immediately, HI=LO=0, no Done; a new Start then completes correctly.

Source files
------------

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//
// Iterative MIPS-style multiply/divide unit with HI/LO result registers.
// Multiplies use shift-add, one multiplier bit per cycle. Divides use
// restoring division, one quotient bit per cycle. Signed operations work on
// operand magnitudes and apply the sign correction when HI/LO are written.
// Every operation has a fixed latency: Start sampled at edge k gives a HI/LO
// update and a Done pulse at edge k+33.
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         asynchronous active-high reset
//   Start       begin an operation (accepted in IDLE only)
//   Op          00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   OperandA    multiplicand / dividend (rs)
//   OperandB    multiplier / divisor (rt)
//   WriteHi     MTHI: load HI from WriteData (IDLE only)
//   WriteLo     MTLO: load LO from WriteData (IDLE only)
//   WriteData   data for MTHI/MTLO
//   ReadSel     0 selects LO, 1 selects HI on ResultData
//   Busy        high while an operation is in progress
//   Done        one-cycle pulse when an operation completes
//   DivByZero   qualifies Done: the divide had a zero divisor
//   ResultData  ReadSel ? HI : LO (combinational)
// -----------------------------------------------------------------------------
module mult_div_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Start,
    input  logic [1:0]   Op,
    input  logic [N-1:0] OperandA,
    input  logic [N-1:0] OperandB,
    input  logic         WriteHi,
    input  logic         WriteLo,
    input  logic [N-1:0] WriteData,
    input  logic         ReadSel,
    output logic         Busy,
    output logic         Done,
    output logic         DivByZero,
    output logic [N-1:0] ResultData
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        FINISH = 2'b10
    } state_t;

    state_t       r_state;
    logic [1:0]   r_op;
    logic         r_neg_a;
    logic         r_neg_b;
    logic [5:0]   r_cnt;
    logic [N-1:0] r_acc;   // partial product high half / partial remainder
    logic [N-1:0] r_mq;    // multiplier shifting out / dividend -> quotient
    logic [N-1:0] r_mag;   // multiplicand or divisor magnitude
    logic [N-1:0] r_hi;
    logic [N-1:0] r_lo;
    logic         r_busy;
    logic         r_done;
    logic         r_dbz;

    // Operand magnitudes; Op[0] marks the signed variants.
    logic         w_a_neg;
    logic         w_b_neg;
    logic [N-1:0] w_a_mag;
    logic [N-1:0] w_b_mag;

    assign w_a_neg = Op[0] & OperandA[N-1];
    assign w_b_neg = Op[0] & OperandB[N-1];
    assign w_a_mag = w_a_neg ? -OperandA : OperandA;
    assign w_b_mag = w_b_neg ? -OperandB : OperandB;

    // One multiply step: add the multiplicand when the current multiplier
    // bit is set, then shift the 65-bit {carry, acc, mq} right by one.
    logic [N:0]   w_mul_sum;
    assign w_mul_sum = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_mag} : {(N+1){1'b0}});

    // One restoring-divide step: shift the next dividend bit into the
    // remainder and subtract the divisor if it fits.
    logic [N:0]   w_div_shift;
    logic         w_div_ok;
    logic [N-1:0] w_div_rem;
    assign w_div_shift = {r_acc, r_mq[N-1]};
    assign w_div_ok    = (w_div_shift >= {1'b0, r_mag});
    // The remainder after a successful subtract is below the divisor, so the
    // truncated difference is exact.
    assign w_div_rem   = w_div_shift[N-1:0] - r_mag;

    logic [N-1:0] w_acc_nxt;
    logic [N-1:0] w_mq_nxt;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        w_acc_nxt = r_acc;
        w_mq_nxt  = r_mq;
        if (r_op[1]) begin
            w_acc_nxt = w_div_ok ? w_div_rem : w_div_shift[N-1:0];
            w_mq_nxt  = {r_mq[N-2:0], w_div_ok};
        end else begin
            w_acc_nxt = w_mul_sum[N:1];
            w_mq_nxt  = {w_mul_sum[0], r_mq[N-1:1]};
        end
    end

    // Sign-corrected results presented to HI/LO in FINISH.
    logic [2*N-1:0] w_prod;
    logic [2*N-1:0] w_prod_fix;
    logic [N-1:0]   w_quo_fix;
    logic [N-1:0]   w_rem_fix;
    logic [N-1:0]   w_hi_res;
    logic [N-1:0]   w_lo_res;
    logic           w_div_zero;

    assign w_prod     = {r_acc, r_mq};
    assign w_prod_fix = (r_op[0] & (r_neg_a ^ r_neg_b)) ? -w_prod : w_prod;
    assign w_quo_fix  = (r_op[0] & (r_neg_a ^ r_neg_b)) ? -r_mq  : r_mq;
    // The remainder follows the sign of the dividend.
    assign w_rem_fix  = (r_op[0] & r_neg_a) ? -r_acc : r_acc;
    assign w_hi_res   = r_op[1] ? w_rem_fix : w_prod_fix[2*N-1:N];
    assign w_lo_res   = r_op[1] ? w_quo_fix : w_prod_fix[N-1:0];
    assign w_div_zero = r_op[1] & (r_mag == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_op    <= '0;
            r_neg_a <= 1'b0;
            r_neg_b <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_mq    <= '0;
            r_mag   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples the pre-edge values, independent of statement
            // order.
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (WriteHi) r_hi <= WriteData;
                    if (WriteLo) r_lo <= WriteData;
                    if (Start) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                        r_op    <= Op;
                        r_neg_a <= w_a_neg;
                        r_neg_b <= w_b_neg;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        if (Op[1]) begin
                            r_mq  <= w_a_mag;
                            r_mag <= w_b_mag;
                        end else begin
                            r_mq  <= w_b_mag;
                            r_mag <= w_a_mag;
                        end
                    end
                end
                RUN: begin
                    r_acc <= w_acc_nxt;
                    r_mq  <= w_mq_nxt;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31) r_state <= FINISH;
                end
                FINISH: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    if (w_div_zero) begin
                        r_dbz <= 1'b1;
                    end else begin
                        r_hi <= w_hi_res;
                        r_lo <= w_lo_res;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Busy       = r_busy;
    assign Done       = r_done;
    assign DivByZero  = r_dbz;
    assign ResultData = ReadSel ? r_hi : r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//
// Directed bench for mult_div_unit. Inputs are driven and outputs sampled on
// the falling clock edge. Each scenario task issues an operation and compares
// the observed latency, Busy span, flags and HI/LO contents against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

    logic        clk;
    logic        rst;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] OperandA;
    logic [31:0] OperandB;
    logic        WriteHi;
    logic        WriteLo;
    logic [31:0] WriteData;
    logic        ReadSel;
    logic        Busy;
    logic        Done;
    logic        DivByZero;
    logic [31:0] ResultData;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    mult_div_unit #(.N(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .Start      (Start),
        .Op         (Op),
        .OperandA   (OperandA),
        .OperandB   (OperandB),
        .WriteHi    (WriteHi),
        .WriteLo    (WriteLo),
        .WriteData  (WriteData),
        .ReadSel    (ReadSel),
        .Busy       (Busy),
        .Done       (Done),
        .DivByZero  (DivByZero),
        .ResultData (ResultData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issues one operation. Must be called at a falling edge; Start is then
    // sampled on the following rising edge (edge k). lat counts falling edges
    // after edge k until Done is seen (33 expected); busy_cnt counts falling
    // edges with Busy high. At inj (if >= 0) a second Start plus MTHI/MTLO of
    // 0xAAAA is attempted mid-run. Operands are scrambled after the Start edge.
    task automatic run_op(
        input  logic [1:0]  op,
        input  logic [31:0] a,
        input  logic [31:0] b,
        input  logic        wh,
        input  logic        wl,
        input  logic [31:0] wd,
        input  int          inj,
        output int          lat,
        output int          busy_cnt,
        output logic        dbz_done,
        output logic        dbz_stray,
        output logic [31:0] mid_hi,
        output logic [31:0] mid_lo,
        output logic [31:0] hi,
        output logic [31:0] lo,
        output logic        done_after
    );
        int j;
        Start = 1'b1; Op = op; OperandA = a; OperandB = b;
        WriteHi = wh; WriteLo = wl; WriteData = wd;
        @(negedge clk);
        Start = 1'b0; WriteHi = 1'b0; WriteLo = 1'b0;
        OperandA = ~a; OperandB = ~b;
        j = 0; busy_cnt = 0; dbz_stray = 1'b0; mid_hi = '0; mid_lo = '0;
        while (Done !== 1'b1 && j < 60) begin
            if (Busy === 1'b1) busy_cnt++;
            if (DivByZero !== 1'b0) dbz_stray = 1'b1;
            if (j == 5) begin
                ReadSel = 1'b0; #1 mid_lo = ResultData;
                ReadSel = 1'b1; #1 mid_hi = ResultData;
                ReadSel = 1'b0;
            end
            if (j == inj) begin
                Start = 1'b1; Op = ~op; WriteHi = 1'b1; WriteLo = 1'b1;
                WriteData = 32'h0000_AAAA;
            end else begin
                Start = 1'b0; WriteHi = 1'b0; WriteLo = 1'b0;
            end
            @(negedge clk);
            j++;
        end
        Start = 1'b0; WriteHi = 1'b0; WriteLo = 1'b0;
        lat = j;
        dbz_done = DivByZero;
        ReadSel = 1'b0; #1 lo = ResultData;
        ReadSel = 1'b1; #1 hi = ResultData;
        ReadSel = 1'b0;
        @(negedge clk);
        done_after = Done;
        if (DivByZero !== 1'b0) dbz_stray = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; Start = 1'b0; Op = '0; OperandA = '0; OperandB = '0;
        WriteHi = 1'b0; WriteLo = 1'b0; WriteData = '0; ReadSel = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", Done); end
        checks++; if (DivByZero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", DivByZero); end
        checks++; if (ResultData !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", ResultData); end
        ReadSel = 1'b1; #1;
        checks++; if (ResultData !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", ResultData); end
        ReadSel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_multu();
        int lat, bc; logic dz, ds, da; logic [31:0] mh, ml, hi, lo;
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, -1, lat, bc, dz, ds, mh, ml, hi, lo, da);
        checks++; if (lat !== 33) begin errors++; $display("FAIL multu_latency: got %0d want 33", lat); end
        checks++; if (bc !== 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d want 33", bc); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", lo); end
        checks++; if (da !== 1'b0) begin errors++; $display("FAIL multu_done_width: got %b want 0", da); end
        checks++; if (dz !== 1'b0 || ds !== 1'b0) begin errors++; $display("FAIL multu_dbz: got %b/%b want 0/0", dz, ds); end
        Busy_check: begin
            checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL multu_busy_idle: got %b want 0", Busy); end
        end
    endtask

    task automatic test_mult();
        int lat, bc; logic dz, ds, da; logic [31:0] mh, ml, hi, lo;
        @(negedge clk);
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 0, 0, 0, -1, lat, bc, dz, ds, mh, ml, hi, lo, da);
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_neg_hi: got %h want ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_neg_lo: got %h want ffffffeb", lo); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL mult_latency: got %0d want 33", lat); end
        @(negedge clk);
        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, -1, lat, bc, dz, ds, mh, ml, hi, lo, da);
        checks++; if (hi !== 32'h4000_0000) begin errors++; $display("FAIL mult_min_hi: got %h want 40000000", hi); end
        checks++; if (lo !== 32'h0000_0000) begin errors++; $display("FAIL mult_min_lo: got %h want 00000000", lo); end
    endtask

    task automatic test_div();
        int lat, bc; logic dz, ds, da; logic [31:0] mh, ml, hi, lo;
        @(negedge clk);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, -1, lat, bc, dz, ds, mh, ml, hi, lo, da);
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_quo: got %h want fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_rem: got %h want ffffffff", hi); end
        checks++; if (lat !== 33 || dz !== 1'b0) begin errors++; $display("FAIL div_latency_dbz: got %0d/%b want 33/0", lat, dz); end
        @(negedge clk);
        run_op(OP_DIVU, 32'd100, 32'd7, 0, 0, 0, -1, lat, bc, dz, ds, mh, ml, hi, lo, da);
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_quo: got %0d want 14", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL divu_rem: got %0d want 2", hi); end
        @(negedge clk);
        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 0, 0, 0, -1, lat, bc, dz, ds, mh, ml, hi, lo, da);
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_negdivisor_quo: got %h want fffffffd", lo); end
        checks++; if (hi !== 32'd1) begin errors++; $display("FAIL div_negdivisor_rem: got %h want 00000001", hi); end
        @(negedge clk);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, -1, lat, bc, dz, ds, mh, ml, hi, lo, da);
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_wrap_quo: got %h want 80000000", lo); end
        checks++; if (hi !== 32'h0000_0000) begin errors++; $display("FAIL div_wrap_rem: got %h want 00000000", hi); end
    endtask

    task automatic test_div_by_zero();
        int lat, bc; logic dz, ds, da; logic [31:0] mh, ml, hi, lo;
        @(negedge clk);
        WriteHi = 1'b1; WriteData = 32'h0000_1234;
        @(negedge clk);
        WriteHi = 1'b0; WriteLo = 1'b1; WriteData = 32'h0000_5678;
        @(negedge clk);
        WriteLo = 1'b0;
        run_op(OP_DIVU, 32'd55, 32'd0, 0, 0, 0, -1, lat, bc, dz, ds, mh, ml, hi, lo, da);
        checks++; if (dz !== 1'b1) begin errors++; $display("FAIL dbz_flag: got %b want 1", dz); end
        checks++; if (ds !== 1'b0) begin errors++; $display("FAIL dbz_outside_done: got %b want 0", ds); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL dbz_latency: got %0d want 33", lat); end
        checks++; if (hi !== 32'h0000_1234) begin errors++; $display("FAIL dbz_hi_kept: got %h want 00001234", hi); end
        checks++; if (lo !== 32'h0000_5678) begin errors++; $display("FAIL dbz_lo_kept: got %h want 00005678", lo); end
        checks++; if (da !== 1'b0) begin errors++; $display("FAIL dbz_done_width: got %b want 0", da); end
    endtask

    task automatic test_write_regs();
        int lat, bc; logic dz, ds, da; logic [31:0] mh, ml, hi, lo;
        @(negedge clk);
        WriteHi = 1'b1; WriteLo = 1'b1; WriteData = 32'hDEAD_BEEF;
        @(negedge clk);
        WriteHi = 1'b0; WriteLo = 1'b0;
        ReadSel = 1'b0; #1;
        checks++; if (ResultData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mt_both_lo: got %h want deadbeef", ResultData); end
        ReadSel = 1'b1; #1;
        checks++; if (ResultData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mt_both_hi: got %h want deadbeef", ResultData); end
        ReadSel = 1'b0;
        @(negedge clk);
        // MTHI on the same edge as Start: HI takes 0x55 during RUN, then the
        // product overwrites both registers.
        run_op(OP_MULTU, 32'd2, 32'd3, 1, 0, 32'h55, -1, lat, bc, dz, ds, mh, ml, hi, lo, da);
        checks++; if (mh !== 32'h55) begin errors++; $display("FAIL start_mthi_mid_hi: got %h want 00000055", mh); end
        checks++; if (ml !== 32'hDEAD_BEEF) begin errors++; $display("FAIL start_mthi_mid_lo: got %h want deadbeef", ml); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL start_mthi_hi: got %h want 00000000", hi); end
        checks++; if (lo !== 32'd6) begin errors++; $display("FAIL start_mthi_lo: got %h want 00000006", lo); end
    endtask

    task automatic test_mid_run_ignore();
        int lat, bc; logic dz, ds, da; logic [31:0] mh, ml, hi, lo;
        @(negedge clk);
        run_op(OP_MULTU, 32'd100, 32'd200, 0, 0, 0, 10, lat, bc, dz, ds, mh, ml, hi, lo, da);
        checks++; if (ml !== 32'd6) begin errors++; $display("FAIL midrun_prev_lo: got %h want 00000006", ml); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL midrun_latency: got %0d want 33", lat); end
        checks++; if (bc !== 33) begin errors++; $display("FAIL midrun_busy_cycles: got %0d want 33", bc); end
        checks++; if (lo !== 32'd20000) begin errors++; $display("FAIL midrun_lo: got %0d want 20000", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL midrun_hi: got %h want 00000000", hi); end
        checks++; if (da !== 1'b0) begin errors++; $display("FAIL midrun_single_done: got %b want 0", da); end
    endtask

    task automatic test_rst_mid_op();
        int lat, bc; logic dz, ds, da; logic [31:0] mh, ml, hi, lo;
        logic saw_done;
        @(negedge clk);
        Start = 1'b1; Op = OP_MULTU; OperandA = 32'hFFFF_FFFF; OperandB = 32'hFFFF_FFFF;
        @(negedge clk);
        Start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", Busy); end
        ReadSel = 1'b0; #1;
        checks++; if (ResultData !== 32'd0) begin errors++; $display("FAIL rst_mid_lo: got %h want 0", ResultData); end
        ReadSel = 1'b1; #1;
        checks++; if (ResultData !== 32'd0) begin errors++; $display("FAIL rst_mid_hi: got %h want 0", ResultData); end
        ReadSel = 1'b0;
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (Done !== 1'b0) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rst_mid_no_done: got %b want 0", saw_done); end
        // Release reset and present Start for the very next rising edge.
        rst = 1'b0;
        run_op(OP_MULTU, 32'd3, 32'd5, 0, 0, 0, -1, lat, bc, dz, ds, mh, ml, hi, lo, da);
        checks++; if (lat !== 33) begin errors++; $display("FAIL rst_restart_latency: got %0d want 33", lat); end
        checks++; if (lo !== 32'd15 || hi !== 32'd0) begin errors++; $display("FAIL rst_restart_result: got %h_%h want 00000000_0000000f", hi, lo); end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_by_zero();
        test_write_regs();
        test_mid_run_ignore();
        test_rst_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
